ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port command RAM (10-bit command word in, 8-bit read data out). Each requester issues opcode-tagged command words over a valid/ready handshake. The block grants the RAM for a whole address+data transaction, forwards words on registered RAM-side outputs, times the read return, and routes read data back to the owning requester. It sits between the two command sources (SPI front-ends / host logic) and the RAM.

## Interface
- ADDR_SIZE, 8: address/data field width; command word is ADDR_SIZE+2 bits, opcode in the top 2 bits.
- TIMEOUT_CYCLES, 255: lock-timeout limit, used only with the timeout feature; must be at least 1.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_cmd  in  ADDR_SIZE+2  requester 0 command word.
- p0_valid  in  1  requester 0 word valid.
- p0_ready  out  1  requester 0 word accepted when valid&ready.
- p0_rdata  out  8  read data returned to requester 0.
- p0_rvalid  out  1  one-cycle pulse, p0_rdata valid.
- p1_cmd / p1_valid / p1_ready / p1_rdata / p1_rvalid: same as the port 0 signals, for requester 1.
- ram_din  out  ADDR_SIZE+2  registered command word to RAM.
- ram_rx_valid  out  1  registered word strobe to RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read-data-valid.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle protocol-error pulse.

## Operation
- Opcodes: 00 WRITE_ADD, 01 WRITE_DATA, 10 READ_ADD, 11 READ_DATA.
  - Write class: 00 and 01. Read class: 10 and 11.
- States: IDLE, LOCK, RD_WAIT.
- IDLE, arbitration:
  - Round-robin pointer `last`; reset value 1, so port 0 wins the first tie.
  - Among ports with valid high, the port other than `last` wins; a lone valid wins outright.
  - Winner gets ready=1 combinationally; the loser gets ready=0.
- IDLE, accepted *_ADD word: forwarded; state goes to LOCK; owner = winner; class recorded.
- IDLE, accepted *_DATA word: dropped, nothing reaches the RAM, err pulses. The RAM address is not owned by anyone.
- LOCK:
  - Only the owner sees ready=1; the other port's ready=0.
  - Same-class *_ADD: forwarded; lock kept (re-address allowed).
  - WRITE_DATA in write class: forwarded; state goes to IDLE; `last` = owner.
  - READ_DATA in read class: forwarded; state goes to RD_WAIT.
  - Other-class word: accepted and dropped; err pulses; lock kept.
- RD_WAIT:
  - No ready on either port.
  - Lasts 2 cycles, then samples ram_dout into the owner's rdata.
  - Pulses the owner's rvalid; `last` = owner; state goes to IDLE.
  - If ram_tx_valid is low at the sample cycle: rvalid still pulses, and err also pulses.
- Idle RAM drive: when no word is forwarded, ram_din=0 and ram_rx_valid=0. This is mandatory because the RAM acts on opcode 11 regardless of strobe.
- Write data never produces rvalid.

## Timing
- Word accepted in cycle T appears on ram_din/ram_rx_valid in T+1 for exactly one cycle.
- Write transaction:
  - ADD accepted T, DATA accepted T+k (k≥1).
  - Next IDLE acceptance possible at T+k+1.
- Read transaction:
  - READ_DATA accepted T, forwarded T+1, RAM output valid T+2.
  - Sampled at the end of T+2; rvalid high in T+3; next acceptance possible from T+3.
- Back-to-back: the owner may present DATA the cycle after ADD is accepted.
- Reset values: ready 0, rdata 0, rvalid 0, ram_din 0, ram_rx_valid 0, busy 0, err 0; state IDLE; `last` = 1.
- Reset mid-transaction: lock released, pending read discarded, no rvalid issued.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - Counter cleared on entering LOCK and on each accepted owner word; counts LOCK cycles.
  - At TIMEOUT_CYCLES cycles: state goes to IDLE, err pulses, `last` = owner.
  - A word presented in the timeout cycle is not accepted.
- Macro undefined: no counter; LOCK is held indefinitely until the matching DATA word arrives.

## Structure
- Shared package ram_ctrl_pkg:
  - Opcode constants WRITE_ADD/WRITE_DATA/READ_ADD/READ_DATA.
  - State enum.
  - Read-return latency constant (2).
- Sub-module rr_arbiter2: 2-way round-robin pick from the valids plus `last`; outputs the one-hot grant.

## Test plan
- Write then read: p0 sends 00_3C, 01_A5, 10_3C, 11_00 → ram_din sequence 0x03C, 0x1A5, 0x23C, 0x300 at T+1 of each accept; p0_rvalid with p0_rdata=0xA5 3 cycles after 11_00 accepted.
- Contention: both valid in IDLE after reset → p0 granted first; p1 stalled (p1_ready=0) through p0's full write pair; p1 granted next; when both are valid again, p0 wins.
- Lock exclusivity: p0 locked after 10_07, p1 valid with 00_FF → p1_ready stays 0, ram_din never shows 0x0FF until p0's 11_xx completes.
- Errors: IDLE 01_11 → err pulse, ram_rx_valid stays 0. Write-locked p0 sends 11_00 → err pulse, lock kept, no read issued.
- Reset: rst asserted one cycle after READ_DATA accept → no rvalid; all outputs 0; ram_din=0 next cycle.
- RAM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: p0 sends 00_10 and nothing else → err pulse at 4th LOCK cycle, busy drops, p1 granted next.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared opcode, state and latency definitions for the command-RAM arbiter.
package ram_ctrl_pkg;

    localparam logic [1:0] WRITE_ADD  = 2'b00;
    localparam logic [1:0] WRITE_DATA = 2'b01;
    localparam logic [1:0] READ_ADD   = 2'b10;
    localparam logic [1:0] READ_DATA  = 2'b11;

    // Cycles from READ_DATA forward to RAM data being sampled.
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK    = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    function automatic logic is_read_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_add_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port other than last_i wins.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) grant_o = last_i ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port command RAM.
// Optional lock timeout enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] p0_cmd,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    output logic [7:0]           p0_rdata,
    output logic                 p0_rvalid,
    input  logic [ADDR_SIZE+1:0] p1_cmd,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    output logic [7:0]           p1_rdata,
    output logic                 p1_rvalid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int         CW      = ADDR_SIZE + 2;
    localparam logic [1:0] RD_LAST = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              cls_q, cls_d;
    logic [1:0]        rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]     din_q, din_d;
    logic              rxv_q, rxv_d;
    logic [1:0][7:0]   rdata_q, rdata_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic [1:0]        valid, grant, ready;
    logic              acc, acc_port;
    logic [CW-1:0]     acc_cmd;
    logic [1:0]        acc_op;

    assign valid = {p1_valid, p0_valid};

    rr_arbiter2 u_rr (
        .valid_i (valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout;
    assign timeout = (state_q == LOCK) && (to_cnt_q == TO_LAST);
`endif

    always_comb begin
        ready = 2'b00;
        case (state_q)
            IDLE:    ready = grant;
            LOCK:    ready[owner_q] = 1'b1;
            default: ready = 2'b00;
        endcase
`ifdef RAM_ARB_TIMEOUT_EN
        // The lock expires this cycle, so nothing may be taken from the owner.
        if (timeout) ready = 2'b00;
`endif
        if (rst) ready = 2'b00;
    end

    assign acc      = |(ready & valid);
    assign acc_port = ready[1] & valid[1];
    assign acc_cmd  = acc_port ? p1_cmd : p0_cmd;
    assign acc_op   = acc_cmd[CW-1 -: 2];

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        cls_d    = cls_q;
        rd_cnt_d = rd_cnt_q;
        din_d    = '0;
        rxv_d    = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        err_d    = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (is_add_op(acc_op)) begin
                        din_d   = acc_cmd;
                        rxv_d   = 1'b1;
                        state_d = LOCK;
                        owner_d = acc_port;
                        cls_d   = is_read_op(acc_op);
`ifdef RAM_ARB_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOCK: begin
`ifdef RAM_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                end
                if (acc) to_cnt_d = '0;
`endif
                if (acc) begin
                    if (is_read_op(acc_op) != cls_q) begin
                        err_d = 1'b1;
                    end else begin
                        din_d = acc_cmd;
                        rxv_d = 1'b1;
                        if (!is_add_op(acc_op)) begin
                            if (cls_q) begin
                                state_d  = RD_WAIT;
                                rd_cnt_d = '0;
                            end else begin
                                state_d = IDLE;
                                last_d  = owner_q;
                            end
                        end
                    end
                end
            end
            RD_WAIT: begin
                // Sample regardless of ram_tx_valid; a missing strobe is flagged, not hidden.
                if (rd_cnt_q == RD_LAST) begin
                    rdata_d[owner_q]  = ram_dout;
                    rvalid_d[owner_q] = 1'b1;
                    err_d             = ~ram_tx_valid;
                    last_d            = owner_q;
                    state_d           = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cls_q    <= 1'b0;
            rd_cnt_q <= '0;
            din_q    <= '0;
            rxv_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cls_q    <= cls_d;
            rd_cnt_q <= rd_cnt_d;
            din_q    <= din_d;
            rxv_q    <= rxv_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`endif

    assign p0_ready     = ready[0];
    assign p1_ready     = ready[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];
    assign p0_rvalid    = rvalid_q[0];
    assign p1_rvalid    = rvalid_q[1];
    assign ram_din      = din_q;
    assign ram_rx_valid = rxv_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

endmodule
